conv_scan_ctrl: RTL and testbench

CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

---
 rtl/conv_scan_ctrl_if.sv | 33 +++
 rtl/conv_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_conv_scan_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_scan_ctrl_if.sv
// Scan-controller bundle: start/stall in from the sequencer, weight-load and MAC-step controls out.
interface conv_scan_ctrl_if #(
  parameter int AW = 4,
  parameter int KW = 2,
  parameter int OW = 5
);
  logic          start;
  logic          stall;
  logic [AW-1:0] w_raddr;
  logic          w_load;
  logic [AW-1:0] w_lidx;
  logic [KW-1:0] x;
  logic [KW-1:0] y;
  logic [OW-1:0] X;
  logic [OW-1:0] Y;
  logic          mac_valid;
  logic          mac_first;
  logic          mac_last;
  logic          busy;
  logic          finish;

  modport master (
    output start, stall,
    input  w_raddr, w_load, w_lidx, x, y, X, Y,
    input  mac_valid, mac_first, mac_last, busy, finish
  );

  modport slave (
    input  start, stall,
    output w_raddr, w_load, w_lidx, x, y, X, Y,
    output mac_valid, mac_first, mac_last, busy, finish
  );
endinterface

// File: rtl/conv_scan_ctrl.sv
// Convolution scan sequencer: loads KSIZE^2 weights (1-cycle memory latency), then walks x,y,X,Y.
// Latency: start->LOAD next cycle; stall freezes the scan counters only (LOAD ignores it).
module conv_scan_ctrl #(
  parameter int KSIZE = 3,
  parameter int OSIZE = 19,
  parameter int AW    = 4
) (
  input logic             clk,
  input logic             xrst,
  conv_scan_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int NTAP = KSIZE * KSIZE;
  localparam int KW   = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int OW   = (OSIZE > 1) ? $clog2(OSIZE) : 1;
  localparam int LW   = $clog2(NTAP + 1);

  localparam logic [KW-1:0] KMAX = KW'(KSIZE - 1);
  localparam logic [OW-1:0] OMAX = OW'(OSIZE - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [1:0]    rst_sync;
  logic          run;
  logic [LW-1:0] lcnt;
  logic [AW-1:0] raddr;
  logic [AW-1:0] lidx;
  logic          wload;
  logic [KW-1:0] cx;
  logic [KW-1:0] cy;
  logic [OW-1:0] cpx;
  logic [OW-1:0] cpy;
  logic          busy_q;
  logic          finish_q;
  logic          scan_q;
  logic          in_load;
  logic          step;
  logic          wrap_x;
  logic          wrap_y;
  logic          wrap_px;
  logic          wrap_py;

  assign run     = rst_sync[1];
  assign in_load = (state == S_LOAD);
  assign step    = (state == S_SCAN) && !bus.stall;
  assign wrap_x  = (cx == KMAX);
  assign wrap_y  = (cy == KMAX);
  assign wrap_px = (cpx == OMAX);
  assign wrap_py = (cpy == OMAX);

  // Start is held off until the release of xrst has passed through two flops.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start && run) state_nxt = S_LOAD;
      S_LOAD: if (lcnt == LW'(NTAP)) state_nxt = S_SCAN;
      S_SCAN: if (step && wrap_x && wrap_y && wrap_px && wrap_py) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      scan_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      finish_q <= (state_nxt == S_DONE);
      scan_q   <= (state_nxt == S_SCAN);
    end
  end

  // lcnt counts LOAD cycles; address k is issued in cycle k and captured one cycle later.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      lcnt  <= '0;
      raddr <= '0;
      wload <= 1'b0;
      lidx  <= '0;
    end else begin
      lcnt  <= (in_load && state_nxt == S_LOAD) ? lcnt + 1'b1 : '0;
      raddr <= (in_load && lcnt < LW'(NTAP - 1)) ? AW'(lcnt + 1'b1) : '0;
      wload <= in_load && (lcnt < LW'(NTAP));
      lidx  <= (in_load && lcnt < LW'(NTAP)) ? raddr : '0;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cx  <= '0;
      cy  <= '0;
      cpx <= '0;
      cpy <= '0;
    end else if (step) begin
      cx <= wrap_x ? '0 : cx + 1'b1;
      if (wrap_x) begin
        cy <= wrap_y ? '0 : cy + 1'b1;
        if (wrap_y) begin
          cpx <= wrap_px ? '0 : cpx + 1'b1;
          if (wrap_px) cpy <= wrap_py ? '0 : cpy + 1'b1;
        end
      end
    end
  end

  assign bus.w_raddr = raddr;
  assign bus.w_load  = wload;
  assign bus.w_lidx  = lidx;
  assign bus.x       = cx;
  assign bus.y       = cy;
  assign bus.X       = cpx;
  assign bus.Y       = cpy;
  assign bus.busy    = busy_q;
  assign bus.finish  = finish_q;

  // A stalled cycle must not count as a MAC step, so valid is gated by this cycle's stall.
  assign bus.mac_valid = scan_q & ~bus.stall;
  assign bus.mac_first = bus.mac_valid & (cx == '0) & (cy == '0);
  assign bus.mac_last  = bus.mac_valid & wrap_x & wrap_y;
endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Bench for conv_scan_ctrl: directed vector table for LOAD/early SCAN, randomized full passes vs a tuple-list model.
module tb_conv_scan_ctrl;
  logic clk;
  logic xrst;

  conv_scan_ctrl_if #(.AW(4), .KW(2), .OW(5)) bus ();

  conv_scan_ctrl #(.KSIZE(3), .OSIZE(19), .AW(4)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  typedef logic [13:0] tup_t;

  typedef struct {
    bit       start;
    bit       stall;
    bit [3:0] raddr;
    bit       wload;
    bit [3:0] lidx;
    bit       busy;
    bit       mv;
    bit       mf;
    bit       ml;
    bit [1:0] tx;
    bit [1:0] ty;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fin_total = 0;
  vec_t tv[16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.finish) fin_total <= fin_total + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] dut_outs();
    return {bus.w_raddr, bus.w_load, bus.w_lidx, bus.x, bus.y, bus.X, bus.Y,
            bus.mac_valid, bus.mac_first, bus.mac_last, bus.busy, bus.finish};
  endfunction

  function automatic logic [27:0] vec_outs(input vec_t v);
    return {v.raddr, v.wload, v.wload ? v.lidx : 4'd0, v.tx, v.ty, 5'd0, 5'd0,
            v.mv, v.mf, v.ml, v.busy, 1'b0};
  endfunction

  function automatic vec_t mkv(input bit st, input bit sl, input int ra, input bit wl,
                               input int li, input bit bz, input bit mv, input bit mf,
                               input bit ml, input int tx, input int ty);
    vec_t v;
    v.start = st;  v.stall = sl;
    v.raddr = 4'(ra); v.wload = wl; v.lidx = 4'(li);
    v.busy = bz; v.mv = mv; v.mf = mf; v.ml = ml;
    v.tx = 2'(tx); v.ty = 2'(ty);
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One pass from IDLE. The model is the ordered list of all (x,y,X,Y) tuples plus the fixed
  // phase lengths: start cycle, 10 LOAD cycles, one SCAN cycle per tuple or stall, one DONE cycle.
  task automatic do_pass(input int pct, input bit spam, input bit hold, input bit abort);
    tup_t q[$];
    tup_t et, dt;
    int t0, k, tf, nst, forced, done_k, ph;
    int e_load, e_scan, e_ctl, nf, nl, nfin;
    bit st, done, emv, emf, eml, ewl;
    int era, eli;
    for (int py = 0; py < 19; py++)
      for (int px = 0; px < 19; px++)
        for (int ty = 0; ty < 3; ty++)
          for (int tx = 0; tx < 3; tx++)
            q.push_back({2'(tx), 2'(ty), 5'(px), 5'(py)});
    t0 = cyc; tf = -1; nst = 0; forced = hold ? 5 : 0; done = 0; done_k = 0;
    e_load = 0; e_scan = 0; e_ctl = 0; nf = 0; nl = 0; nfin = 0;
    for (int it = 0; it < 9000; it++) begin
      k = cyc - t0;
      if (k == 0) ph = 0;
      else if (k <= 10) ph = 1;
      else if (q.size() > 0) ph = 2;
      else if (!done) ph = 3;
      else ph = 0;
      if (abort && ph == 2 && q[0] == {2'd0, 2'd1, 5'd10, 5'd12}) begin
        xrst = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk("abort_outputs_zero", int'(dut_outs()), 0);
        return;
      end
      if (ph == 2 && forced > 0 && q[0] == {2'd1, 2'd2, 5'd7, 5'd3}) begin
        st = 1'b1;
        forced--;
      end else begin
        st = ($urandom_range(99) < pct);
      end
      if (ph == 2 && st) nst++;
      bus.stall = st;
      bus.start = (k == 0) || (spam && (k == 5 || k == 500 || ph == 3));
      @(negedge clk);
      era = (k >= 1 && k <= 9) ? k - 1 : 0;
      ewl = (k >= 2 && k <= 10);
      eli = ewl ? k - 2 : 0;
      if (int'(bus.w_raddr) != era || bus.w_load != ewl || (ewl && int'(bus.w_lidx) != eli))
        e_load++;
      if (ph == 2) begin
        et  = q[0];
        emv = !st;
        emf = emv && et[13:12] == 2'd0 && et[11:10] == 2'd0;
        eml = emv && et[13:12] == 2'd2 && et[11:10] == 2'd2;
      end else begin
        et = '0; emv = 0; emf = 0; eml = 0;
      end
      dt = {bus.x, bus.y, bus.X, bus.Y};
      if (dt != et || bus.mac_valid != emv || bus.mac_first != emf || bus.mac_last != eml)
        e_scan++;
      if (bus.busy != (ph != 0) || bus.finish != (ph == 3)) e_ctl++;
      if (bus.mac_first) nf++;
      if (bus.mac_last) nl++;
      if (bus.finish) begin
        nfin++;
        tf = cyc - t0;
      end
      if (ph == 2 && !st) void'(q.pop_front());
      if (ph == 3) begin
        done = 1;
        done_k = k;
      end
      next_cycle();
      if (done && k >= done_k + 3) break;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    chk("pass_done", int'(done), 1);
    chk("pass_time", tf, 3260 + nst);
    chk("finish_pulses", nfin, 1);
    chk("first_pulses", nf, 361);
    chk("last_pulses", nl, 361);
    chk("load_errs", e_load, 0);
    chk("scan_errs", e_scan, 0);
    chk("ctl_errs", e_ctl, 0);
  endtask

  initial begin
    tv[0] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      tv[k] = mkv(k == 3, 1, (k <= 9) ? k - 1 : 0, k >= 2, (k >= 2) ? k - 2 : 0, 1, 0, 0, 0, 0, 0);
    tv[11] = mkv(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    tv[12] = mkv(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tv[13] = mkv(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    tv[14] = mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0);
    tv[15] = mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);

    xrst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    #2 xrst = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("reset_state", int'(dut_outs()), 0);

    // start coinciding with the first edge after release must be ignored
    next_cycle();
    xrst = 1'b1;
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    @(negedge clk);
    chk("release_edge1_busy", int'(bus.busy), 0);
    repeat (3) next_cycle();

    for (int i = 0; i < 16; i++) begin
      logic [27:0] got;
      bus.start = tv[i].start;
      bus.stall = tv[i].stall;
      @(negedge clk);
      got = dut_outs();
      if (!bus.w_load) got[22:19] = 4'd0;
      chk($sformatf("vec%0d", i), int'(got), int'(vec_outs(tv[i])));
      next_cycle();
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    xrst = 1'b0;
    #1;
    chk("vec_abort_zero", int'(dut_outs()), 0);
    next_cycle();
    xrst = 1'b1;
    repeat (4) next_cycle();

    do_pass(0, 0, 0, 0);
    do_pass(20, 1, 1, 0);
    do_pass(0, 0, 0, 1);
    next_cycle();
    xrst = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("idle_after_abort", int'(bus.busy), 0);
    next_cycle();
    do_pass(0, 0, 0, 0);
    repeat (2) next_cycle();
    chk("finish_total", fin_total, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
